// File: rtl/vpu_max_reduce_seq.sv
// vpu_max_reduce_seq: folds an N-element unsigned vector, two elements per beat, through one external MAX ALU into a running max; ports: start/len/abort control, in_* beat stream, alu_* operand/result, res_* result handshake
module vpu_max_reduce_seq #(
  parameter int OPERAND_WIDTH   = 32,
  parameter int SRAM_R_PORT_CNT = 3,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [LEN_WIDTH-1:0]         len_i,
  input  logic                         abort_i,
  output logic                         busy_o,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [2*OPERAND_WIDTH-1:0]   in_data_i,
  output logic                         alu_en_o,
  output logic [OPERAND_WIDTH-1:0]     alu_op_0_o,
  output logic [OPERAND_WIDTH-1:0]     alu_op_1_o,
  output logic [OPERAND_WIDTH-1:0]     alu_op_2_o,
  output logic [SRAM_R_PORT_CNT-1:0]   alu_op_valid_o,
  input  logic [OPERAND_WIDTH-1:0]     alu_result_i,
  output logic                         res_valid_o,
  output logic [OPERAND_WIDTH-1:0]     res_data_o,
  input  logic                         res_ready_i
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [LEN_WIDTH-1:0] TWO = LEN_WIDTH'(2);
  state_t                 state_q, state_d;
  logic [OPERAND_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic                   fire;
  logic                   pair;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    fire    = in_valid_i & (state_q == RUN);
    pair    = rem_q >= TWO;
    if (state_q == IDLE && start_i) begin
      state_d = (len_i != '0) ? RUN : DONE;
      acc_d   = '0;
      rem_d   = len_i;
    end else if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      acc_d   = '0;
      rem_d   = '0;
    end else if (fire) begin
      acc_d   = alu_result_i;
      rem_d   = rem_q - (pair ? TWO : rem_q);
      state_d = (rem_q <= TWO) ? DONE : RUN;
    end else if (state_q == DONE && res_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end
  assign busy_o         = state_q != IDLE;
  assign in_ready_o     = state_q == RUN;
  assign alu_en_o       = fire;
  assign alu_op_0_o     = fire ? acc_q : '0;
  assign alu_op_1_o     = fire ? in_data_i[OPERAND_WIDTH-1:0] : '0;
  assign alu_op_2_o     = fire ? in_data_i[2*OPERAND_WIDTH-1:OPERAND_WIDTH] : '0;
  // op_2 is only qualified when a second element remains; an odd tail ignores b
  assign alu_op_valid_o = fire ? {pair, {(SRAM_R_PORT_CNT-1){1'b1}}} : '0;
  assign res_valid_o    = state_q == DONE;
  assign res_data_o     = (state_q == DONE) ? acc_q : '0;
endmodule

// File: tb/tb_vpu_max_reduce_seq.sv
// tb_vpu_max_reduce_seq: directed and randomized max-reduction runs against a queue-based reference with a behavioural MAX ALU
module tb_vpu_max_reduce_seq;
  logic        clk = 0;
  logic        rst_n;
  logic        start_i, abort_i, in_valid_i, res_ready_i;
  logic [15:0] len_i;
  logic [63:0] in_data_i;
  logic        busy_o, in_ready_o, alu_en_o, res_valid_o;
  logic [31:0] alu_op_0_o, alu_op_1_o, alu_op_2_o, alu_result_i, res_data_o;
  logic [2:0]  alu_op_valid_o;
  int          total = 0, passed = 0, fails = 0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  vpu_max_reduce_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .busy_o(busy_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .alu_en_o(alu_en_o), .alu_op_0_o(alu_op_0_o), .alu_op_1_o(alu_op_1_o),
    .alu_op_2_o(alu_op_2_o), .alu_op_valid_o(alu_op_valid_o), .alu_result_i(alu_result_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_ready_i(res_ready_i)
  );
  always_comb begin
    alu_result_i = alu_op_0_o;
    if (alu_op_valid_o[1] && alu_op_1_o > alu_result_i) alu_result_i = alu_op_1_o;
    if (alu_op_valid_o[2] && alu_op_2_o > alu_result_i) alu_result_i = alu_op_2_o;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, in_ready_o, 0);
    chk({tag, "_alu_en"}, alu_en_o, 0);
    chk({tag, "_ops"}, {alu_op_0_o, alu_op_1_o | alu_op_2_o}, 0);
    chk({tag, "_opv"}, alu_op_valid_o, 0);
    chk({tag, "_res_valid"}, res_valid_o, 0);
    chk({tag, "_res_data"}, res_data_o, 0);
  endtask
  task automatic run(input logic [31:0] el[$], input bit bubbles, input int hold);
    int          n;
    logic [31:0] exp_max, a, b;
    bit          has_b;
    n = el.size();
    exp_max = 0;
    start_i = 1; len_i = 16'(n);
    @(posedge clk); #1;
    start_i = 0;
    chk("busy_start", busy_o, 1);
    chk("ready_start", in_ready_o, n != 0);
    for (int k = 0; k < n; k += 2) begin
      has_b = (k + 1 < n);
      a = el[k];
      b = has_b ? el[k+1] : 32'hFFFF_FFFF;
      if (bubbles) begin
        in_valid_i = 0; start_i = 1; len_i = 16'd1;
        #1;
        chk("bubble_alu_en", alu_en_o, 0);
        chk("bubble_opv", alu_op_valid_o, 0);
        @(posedge clk); #1;
        start_i = 0;
      end
      in_valid_i = 1; in_data_i = {b, a};
      #1;
      chk("beat_alu_en", alu_en_o, 1);
      chk("beat_op0", alu_op_0_o, exp_max);
      chk("beat_op1", alu_op_1_o, a);
      chk("beat_op2", alu_op_2_o, b);
      chk("beat_opv", alu_op_valid_o, {has_b, 2'b11});
      @(posedge clk); #1;
      in_valid_i = 0;
      if (a > exp_max) exp_max = a;
      if (has_b && b > exp_max) exp_max = b;
    end
    chk("done_valid", res_valid_o, 1);
    chk("done_data", res_data_o, exp_max);
    chk("done_ready", in_ready_o, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid_i = 1; start_i = 1; len_i = 16'd7;
      #1;
      chk("hold_alu_en", alu_en_o, 0);
      @(posedge clk); #1;
      chk("hold_valid", res_valid_o, 1);
      chk("hold_data", res_data_o, exp_max);
    end
    in_valid_i = 0; start_i = 0; res_ready_i = 1;
    @(posedge clk); #1;
    res_ready_i = 0;
    chk("post_busy", busy_o, 0);
    chk("post_valid", res_valid_o, 0);
  endtask
  initial begin
    rst_n = 0; start_i = 0; abort_i = 0; in_valid_i = 0; res_ready_i = 0;
    len_i = 0; in_data_i = 0;
    #3;
    chk_idle_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    chk_idle_outputs("idle");
    q = {32'd5, 32'd9, 32'd3, 32'd7};
    run(q, 0, 0);
    q = {32'd2, 32'd1, 32'd8};
    run(q, 0, 0);
    q = {};
    run(q, 0, 1);
    q = {32'd11, 32'hDEAD_BEEF, 32'd4, 32'h8000_0001, 32'd0, 32'hDEAD_BEF0};
    run(q, 1, 5);
    for (int r = 0; r < 6; r++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(9, 1)); i++) q.push_back($urandom);
      run(q, r[0], r % 3);
    end
    start_i = 1; len_i = 16'd5;
    @(posedge clk); #1;
    start_i = 0; in_valid_i = 1; in_data_i = {32'd1, 32'hF000_0000};
    @(posedge clk); #1;
    in_data_i = {32'hFFFF_FFFF, 32'd3}; abort_i = 1;
    #1;
    chk("abort_alu_en", alu_en_o, 1);
    chk("abort_op0", alu_op_0_o, 32'hF000_0000);
    @(posedge clk); #1;
    abort_i = 0; in_valid_i = 0;
    chk_idle_outputs("abort");
    q = {32'd6, 32'd2};
    run(q, 0, 0);
    start_i = 1; len_i = 0;
    @(posedge clk); #1;
    start_i = 0; abort_i = 1; res_ready_i = 1;
    chk("abort_done_valid", res_valid_o, 1);
    @(posedge clk); #1;
    abort_i = 0; res_ready_i = 0;
    chk_idle_outputs("abort_done");
    start_i = 1; len_i = 16'd6;
    @(posedge clk); #1;
    start_i = 0; in_valid_i = 1; in_data_i = {32'hFFFF_FFF0, 32'hFFFF_FFFE};
    @(posedge clk); #1;
    in_data_i = {32'd9, 32'd8};
    #1;
    rst_n = 0;
    #1;
    chk_idle_outputs("async_rst");
    @(posedge clk); #1;
    rst_n = 1; in_valid_i = 0;
    q = {32'd10, 32'd20, 32'd30, 32'd40};
    run(q, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
